// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory controller:
//            controller state encoding, active-low request polarities and
//            the wait-state counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } dmem_state_e;

  // Request encodings from the load/store unit (both active low)
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WE_STORE  = 1'b0;

  // Width of the wait-state counter (covers WAIT_STATES up to 15)
  localparam int WAIT_CNT_W = 4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH_WORDS x 32 single-port SRAM model built from four byte
//            lanes. Synchronous per-lane write, registered read. The read
//            register only updates on a read request, so a write leaves the
//            last read word on the output.
// Ports    : clk       - clock
//            rst       - asynchronous active-high reset (read register only)
//            i_rd_en   - capture the addressed word into the read register
//            i_rd_clr  - with i_rd_en, capture zero instead of array data
//            i_wr_be   - per-byte write enables (nonzero means write)
//            i_idx     - word index
//            i_wdata   - lane-aligned write data
//            o_rdata   - registered read word
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_rd_en,
  input  logic                           i_rd_clr,
  input  logic [3:0]                     i_wr_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    // Array storage is intentionally not reset
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_byte_d;
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (i_wr_be[g]) begin
        mem[i_idx] <= i_wdata[8*g +: 8];
      end
    end

    always_comb begin
      rd_byte_d = rd_byte_q;
      if (i_rd_en) begin
        rd_byte_d = i_rd_clr ? 8'h00 : mem[i_idx];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_byte_q <= 8'h00;
      end else begin
        rd_byte_q <= rd_byte_d;
      end
    end

    assign o_rdata[8*g +: 8] = rd_byte_q;
  end

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_controller
// Purpose  : Multi-cycle data-memory controller behind the load/store unit.
//            Latches an active-low request in IDLE, spends WAIT_STATES cycles
//            in WAIT, commits the access on the edge entering RESPOND and
//            presents a one-cycle (or stall-extended) valid response.
//            Optional feature macro: DMEM_ACCESS_FAULT_EN - when defined,
//            byte addresses >= DEPTH_WORDS*4 are flagged with accessFault,
//            stores to them write nothing and loads return zero. When
//            undefined, the word index simply wraps and accessFault is 0.
// Ports    : clk, reset                  - clock, async active-high reset
//            chipSelect, writeEnable     - active-low request and store select
//            writeMask                   - per-byte store enables
//            address                     - byte address (bits [1:0] ignored)
//            dataMemoryWrite             - lane-aligned store data
//            stallMemoryWriteDataMemory  - holds the response in RESPOND
//            dataMemoryRead              - registered load word
//            validDataMemory             - response strobe
//            memStall                    - pipeline stall while in flight
//            accessFault                 - out-of-range response flag
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_controller
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipSelect,
  input  logic        writeEnable,
  input  logic [3:0]  writeMask,
  input  logic [31:0] address,
  input  logic [31:0] dataMemoryWrite,
  input  logic        stallMemoryWriteDataMemory,
  output logic [31:0] dataMemoryRead,
  output logic        validDataMemory,
  output logic        memStall,
  output logic        accessFault
);

  localparam int c_idx_w = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] c_wait_init =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_e             state_d, state_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_d, wait_cnt_q;
  logic [c_idx_w-1:0]      idx_d, idx_q;
  logic                    store_d, store_q;
  logic [3:0]              mask_d, mask_q;
  logic [31:0]             wdata_d, wdata_q;
  logic                    oob_d, oob_q;
  logic                    valid_d, valid_q;
  logic                    fault_d, fault_q;

  logic                    w_req;
  logic                    w_req_oob;
  logic [c_idx_w-1:0]      w_req_idx;
  logic                    w_commit;
  logic                    w_unused_addr;

  // A request is ignored while reset is held so the array cannot be written
  // by a request that is present during reset.
  assign w_req     = (chipSelect == CS_ACTIVE) && !reset;
  assign w_req_idx = address[c_idx_w+1:2];

`ifdef DMEM_ACCESS_FAULT_EN
  assign w_req_oob = |address[31:c_idx_w+2];
`else
  assign w_req_oob = 1'b0;
`endif

  assign w_unused_addr = ^{address[1:0], address[31:c_idx_w+2]};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    store_d    = store_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    oob_d      = oob_q;
    w_commit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_req) begin
          idx_d   = w_req_idx;
          store_d = (writeEnable == WE_STORE);
          mask_d  = writeMask;
          wdata_d = dataMemoryWrite;
          oob_d   = w_req_oob;
          if (WAIT_STATES == 0) begin
            state_d  = RESPOND;
            w_commit = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = c_wait_init;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d  = RESPOND;
          w_commit = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESPOND: begin
        if (!stallMemoryWriteDataMemory) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == RESPOND);
    // The fault flag is decided at the commit edge and then held alongside
    // valid for as long as the response is stalled.
    fault_d = (state_d == RESPOND) && (w_commit ? oob_d : fault_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      store_q    <= 1'b0;
      mask_q     <= 4'h0;
      wdata_q    <= 32'h0;
      oob_q      <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      store_q    <= store_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      oob_q      <= oob_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  // The *_d request fields are the live inputs when committing straight out
  // of IDLE (zero wait states) and the latched copy when committing from
  // WAIT, so they always describe the access being committed.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .rst      (reset),
    .i_rd_en  (w_commit && !store_d),
    .i_rd_clr (oob_d),
    .i_wr_be  ((w_commit && store_d && !oob_d) ? mask_d : 4'h0),
    .i_idx    (idx_d),
    .i_wdata  (wdata_d),
    .o_rdata  (dataMemoryRead)
  );

  assign memStall        = !reset && ((state_q == IDLE && w_req) || state_q == WAIT);
  assign validDataMemory = valid_q;
  assign accessFault     = fault_q;

endmodule : data_memory_controller
`default_nettype wire

// File: tb/tb_data_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_controller
// Purpose  : Self-checking bench for data_memory_controller. Two instances
//            share data/control inputs but have separate chip selects: one
//            with WAIT_STATES=2, one with WAIT_STATES=0. Expected responses
//            are pushed to a scoreboard queue when a request is issued and
//            compared while the DUT shows valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_a, cs_b;
  logic        we_n;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ext_stall;

  logic [31:0] rd_a, rd_b;
  logic        valid_a, valid_b, stall_a, stall_b, fault_a, fault_b;

  always #5 clk = ~clk;

  data_memory_controller #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .chipSelect                 (cs_a),
    .writeEnable                (we_n),
    .writeMask                  (mask),
    .address                    (addr),
    .dataMemoryWrite            (wdata),
    .stallMemoryWriteDataMemory (ext_stall),
    .dataMemoryRead             (rd_a),
    .validDataMemory            (valid_a),
    .memStall                   (stall_a),
    .accessFault                (fault_a)
  );

  data_memory_controller #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk                        (clk),
    .reset                      (reset),
    .chipSelect                 (cs_b),
    .writeEnable                (we_n),
    .writeMask                  (mask),
    .address                    (addr),
    .dataMemoryWrite            (wdata),
    .stallMemoryWriteDataMemory (ext_stall),
    .dataMemoryRead             (rd_b),
    .validDataMemory            (valid_b),
    .memStall                   (stall_b),
    .accessFault                (fault_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];
  int          n_vec = 0;
  int          n_err = 0;

  // Issue one request to instance sel (0: WAIT_STATES=2, 1: WAIT_STATES=0)
  // starting in the current low clock phase, holding the external stall for
  // `hold` response cycles, and check the whole transaction.
  task automatic do_req(input int sel, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input int hold);
    exp_t        e;
    exp_t        cur;
    int          idx;
    int          ws;
    bit          oob;
    bit          done;
    int          n_stall;
    int          n_valid;
    int          first_valid;
    logic [31:0] w;
    logic        o_stall, o_valid, o_fault;
    logic [31:0] o_rd;

    ws          = (sel == 1) ? 0 : 2;
    idx         = int'(a[11:2]);
`ifdef DMEM_ACCESS_FAULT_EN
    oob         = (a >= 32'd4096);
`else
    oob         = 1'b0;
`endif
    if (st) begin
      e.data  = last_rd[sel];
      e.fault = oob;
      if (!oob) begin
        w = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++) begin
          if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        model[idx] = w;
      end
    end else begin
      e.data  = oob ? 32'h0 : model[idx];
      e.fault = oob;
      last_rd[sel] = e.data;
    end
    sbq.push_back(e);

    we_n      = st ? 1'b0 : 1'b1;
    addr      = a;
    wdata     = d;
    mask      = m;
    ext_stall = (hold > 0);
    if (sel == 1) cs_b = 1'b0; else cs_a = 1'b0;
    #1;

    done        = 1'b0;
    n_stall     = 0;
    n_valid     = 0;
    first_valid = -1;
    cur         = sbq[0];
    for (int c = 0; c < 60 && !done; c++) begin
      o_stall = (sel == 1) ? stall_b : stall_a;
      o_valid = (sel == 1) ? valid_b : valid_a;
      o_fault = (sel == 1) ? fault_b : fault_a;
      o_rd    = (sel == 1) ? rd_b    : rd_a;
      if (o_stall === 1'b1) n_stall++;
      if (o_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        n_valid++;
        n_vec++;
        if (o_rd !== cur.data) begin
          n_err++;
          $display("FAIL rdata addr=%h cyc=%0d: got %h want %h", a, c, o_rd, cur.data);
        end
        n_vec++;
        if (o_fault !== cur.fault) begin
          n_err++;
          $display("FAIL fault addr=%h cyc=%0d: got %b want %b", a, c, o_fault, cur.fault);
        end
        if (n_valid > hold) ext_stall = 1'b0;
      end else if (n_valid > 0) begin
        done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        cs_a = 1'b1;
        cs_b = 1'b1;
        #1;
      end
    end
    void'(sbq.pop_front());

    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout addr=%h: got no completed response want one", a);
    end
    n_vec++;
    if (n_stall != ws + 1) begin
      n_err++;
      $display("FAIL stall_cycles addr=%h: got %0d want %0d", a, n_stall, ws + 1);
    end
    n_vec++;
    if (first_valid != ws + 1) begin
      n_err++;
      $display("FAIL valid_latency addr=%h: got %0d want %0d", a, first_valid, ws + 1);
    end
    n_vec++;
    if (n_valid != hold + 1) begin
      n_err++;
      $display("FAIL valid_cycles addr=%h: got %0d want %0d", a, n_valid, hold + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cs_a  = 1'b0;   // request present during reset must not raise memStall
    cs_b  = 1'b1;
    we_n  = 1'b1;
    mask  = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    ext_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (stall_a !== 1'b0) begin n_err++; $display("FAIL reset_memStall: got %b want 0", stall_a); end
    n_vec++;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    n_vec++;
    if (rd_a !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 00000000", rd_a); end
    n_vec++;
    if (fault_a !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault_a); end
    @(negedge clk);
    cs_a  = 1'b1;
    reset = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    #1;
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_byte_mask();
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    do_req(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    n_vec++;
    if (rd_a !== 32'h1122AA44) begin
      n_err++;
      $display("FAIL byte_mask_word: got %h want 1122aa44", rd_a);
    end
    // Zero-mask store completes but leaves the word alone
    do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
  endtask

  task automatic test_wait0();
    do_req(1, 1'b1, 32'h80, 32'hA5A5_0F0F, 4'hF, 0);
    do_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 0);
  endtask

  task automatic test_ext_stall();
    do_req(0, 1'b1, 32'h30, 32'h1357_9BDF, 4'hF, 3);
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 3);
  endtask

  task automatic test_reset_in_wait();
    do_req(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0);
    we_n  = 1'b0;
    addr  = 32'h40;
    wdata = 32'h55555555;
    mask  = 4'hF;
    cs_a  = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (stall_a !== 1'b1) begin n_err++; $display("FAIL wait_memStall: got %b want 1", stall_a); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (stall_a !== 1'b0) begin n_err++; $display("FAIL async_reset_memStall: got %b want 0", stall_a); end
    n_vec++;
    if (valid_a !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b want 0", valid_a); end
    n_vec++;
    if (rd_a !== 32'h0) begin n_err++; $display("FAIL async_reset_rdata: got %h want 00000000", rd_a); end
    cs_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    #1;
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 0);
  endtask

  task automatic test_fault();
    do_req(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 0);
    // Wraps to word 0 without the fault feature, faults with it
    do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
      do_req(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 0);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_mask();
    test_wait0();
    test_ext_stall();
    test_reset_in_wait();
    test_fault();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_data_memory_controller
`default_nettype wire

// File: doc/data_memory_controller.md
# data_memory_controller

Multi-cycle data-memory controller sitting directly downstream of the load/store unit in the memory-write stage. It accepts the unit's active-low chip-select/write-enable request, byte-mask and word address, and models a wait-stated SRAM. It returns the full 32-bit word for loads, from which the load/store unit extracts bytes and halfwords. It also drives the pipeline stall and the one-cycle data-valid strobe.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, at least 4.
- WAIT_STATES, 2: extra access cycles per request; legal range 0..15.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- chipSelect  in  1  active low; 0 means a request is present.
- writeEnable  in  1  active low; 0 means store, 1 means load.
- writeMask  in  4  per-byte store enables; bit i covers bits [8i+7:8i].
- address  in  32  byte address; bits [1:0] are ignored here.
- dataMemoryWrite  in  32  store data, already lane-aligned.
- stallMemoryWriteDataMemory  in  1  external pipeline stall; while high, the response is held.
- dataMemoryRead  out  32  registered read word.
- validDataMemory  out  1  response strobe.
- memStall  out  1  stalls the pipeline while an access is in flight.
- accessFault  out  1  out-of-range indication; tied 0 unless the macro in Configuration is defined.

## Operation
- States: IDLE, WAIT, RESPOND.
- Word index is address[$clog2(DEPTH_WORDS)+1:2].
- IDLE
  - On chipSelect==0, latch the index, the op, the mask and the data.
  - Next state is WAIT with waitCnt=WAIT_STATES-1, or RESPOND directly if WAIT_STATES==0.
- WAIT
  - waitCnt decrements each cycle.
  - At waitCnt==0, go to RESPOND.
- Commit edge (the edge that enters RESPOND)
  - Store: each byte lane with writeMask=1 is written; other lanes are unchanged.
  - Load: the addressed word is captured into dataMemoryRead.
  - A store does not change dataMemoryRead.
- RESPOND
  - validDataMemory=1 and memStall=0.
  - If stallMemoryWriteDataMemory==1: stay in RESPOND. Valid and data are held, and nothing is re-committed.
  - Otherwise go to IDLE. The next request is only sampled in IDLE.
- memStall = (state==IDLE && chipSelect==0) || state==WAIT. It is combinational.
- While reset is high, memStall and validDataMemory are forced to 0.
- Store with writeMask==0 completes normally with no array change.
- Array contents are not reset.

## Timing
- Request presented in IDLE at cycle T:
  - memStall is high for cycles T..T+WAIT_STATES.
  - The commit edge is at the end of cycle T+WAIT_STATES.
  - validDataMemory is high at cycle T+WAIT_STATES+1.
- Minimum occupancy is WAIT_STATES+2 cycles per request, with back-to-back requests.
- Reset values: state=IDLE, waitCnt=0, dataMemoryRead=0, validDataMemory=0, memStall=0, accessFault=0.
- Reset during WAIT, before the commit edge: the access is abandoned, no byte is written, and the controller returns to IDLE.
- Request changes during WAIT are ignored, because the request was latched in IDLE.

## Configuration
- Macro: DMEM_ACCESS_FAULT_EN.
- Defined: an address ≥ DEPTH_WORDS*4 is out of range.
  - Stores write nothing.
  - Loads return 0.
  - accessFault=1 in RESPOND, aligned with validDataMemory and held with it.
- Undefined: upper address bits are ignored, so the index wraps modulo DEPTH_WORDS, and accessFault is constant 0.

## Structure
- Package dmem_pkg holds:
  - the state enum typedef (IDLE, WAIT, RESPOND);
  - constants CS_ACTIVE=1'b0 and WE_STORE=1'b0;
  - the 4-bit waitCnt width constant.
- Sub-module dmem_array: DEPTH_WORDS×32 byte-lane SRAM with synchronous masked write, registered read and a single port. The FSM sits in data_memory_controller.

## Test plan
- Store then load, WAIT_STATES=2:
  - Stimulus: sw 0xDEADBEEF to 0x10, mask 1111, then lw 0x10.
  - Response: each request has memStall for 3 cycles, then valid for 1 cycle; dataMemoryRead=0xDEADBEEF.
- Byte-masked store:
  - Stimulus: preload 0x11223344 at 0x20, store 0x0000AA00 with mask 0010, then lw 0x20.
  - Response: 0x1122AA44.
- WAIT_STATES=0:
  - Stimulus: a load.
  - Response: memStall for exactly 1 cycle, with valid in the next cycle.
- External stall in RESPOND:
  - Stimulus: hold stallMemoryWriteDataMemory high for 3 cycles during RESPOND.
  - Response: valid and data stay stable for all 3 cycles, and the store is committed once.
- Reset in WAIT:
  - Stimulus: assert reset in the first WAIT cycle of sw 0x55555555 to 0x40.
  - Response: the outputs go to their reset values asynchronously, and a later lw 0x40 returns the prior contents.
- DMEM_ACCESS_FAULT_EN with DEPTH_WORDS=1024:
  - Stimulus: lw 0x1000.
  - Response: accessFault=1 with valid, and data=0.
  - Without the macro, the same load returns word 0.
